// File: rtl/tns_dec_pipe.sv
// rtl/tns_dec_pipe.sv - pipelined multi-lane TNS (3C1S CAC) codeword decoder
// Optional build macro: TNS_DEC_OVF_EN (enables the per-lane out_ovf flag)

`ifndef BLEN11_C
`define BLEN11_C 27
`endif

package tns_dec_pkg;
  localparam int TNS_CW = 31;
  localparam int TNS_DW = `BLEN11_C;

  // Default weight table, bit-ascending: TNS01_C, TNS01_B, TNS01_A, ... TNS11_C.
  // Each weight is the sum of the three below it, seeded 1, 2, 4.
  function automatic logic [TNS_CW*TNS_DW-1:0] tns_weights();
    logic [TNS_CW*TNS_DW-1:0] v;
    logic [31:0] t0, t1, t2, tn;
    v  = '0;
    t0 = 32'd1;
    t1 = 32'd2;
    t2 = 32'd4;
    for (int i = 0; i < TNS_CW; i++) begin
      v[i*TNS_DW +: TNS_DW] = TNS_DW'(t0);
      tn = t0 + t1 + t2;
      t0 = t1;
      t1 = t2;
      t2 = tn;
    end
    return v;
  endfunction
endpackage

module tns_dec_pipe #(
  parameter int LANES  = 1,
  parameter int CODE_W = 31,
  parameter int DATA_W = `BLEN11_C,
  parameter logic [CODE_W*DATA_W-1:0] WEIGHTS = tns_dec_pkg::tns_weights(),
  parameter int GRP    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*CODE_W-1:0] in_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_ovf,
  output logic [31:0]             word_cnt
);

  localparam int NGRP  = (CODE_W + GRP - 1) / GRP;
  localparam int PAD_W = NGRP * GRP;
`ifdef TNS_DEC_OVF_EN
  localparam int W_INT = DATA_W + $clog2(CODE_W);
  localparam int SUM_W = W_INT;
`else
  localparam int SUM_W = DATA_W;
`endif

  logic                    s1_valid_q, s1_valid_d;
  logic [LANES*CODE_W-1:0] s1_code_q, s1_code_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [SUM_W-1:0]        s2_sum [LANES][NGRP];
  logic [SUM_W-1:0]        s2_psum_q [LANES][NGRP];
  logic [SUM_W-1:0]        s2_psum_d [LANES][NGRP];
  logic                    s3_valid_q, s3_valid_d;
  logic [LANES*DATA_W-1:0] s3_data_q, s3_data_d;
  logic [31:0]             cnt_q, cnt_d;
  logic                    s1_load, s2_load, s3_load, out_xfer;

  // Weights and codewords zero-padded to a whole number of groups
  logic [SUM_W-1:0] w_ext [PAD_W];
  logic [PAD_W-1:0] code_pad [LANES];

  for (genvar i = 0; i < PAD_W; i++) begin : g_wext
    if (i < CODE_W) begin : g_real
      assign w_ext[i] = SUM_W'(WEIGHTS[i*DATA_W +: DATA_W]);
    end else begin : g_pad
      assign w_ext[i] = '0;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_cpad
    assign code_pad[l] = PAD_W'(s1_code_q[l*CODE_W +: CODE_W]);
  end

  // Elastic handshake: a stage loads when empty or when its word leaves this cycle
  assign s3_load  = !s3_valid_q || out_ready;
  assign s2_load  = !s2_valid_q || s3_load;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_xfer = s3_valid_q && out_ready;

  // Stage 1 next state: capture the codewords on an input transfer
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
      end
    end
  end

  // Stage 2 combinational: weighted partial sum of each GRP-bit group
  always_comb begin
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int g = 0; g < NGRP; g++) begin
        acc = '0;
        for (int j = 0; j < GRP; j++) begin
          acc = acc + (code_pad[l][g*GRP+j] ? w_ext[g*GRP+j] : '0);
        end
        s2_sum[l][g] = acc;
      end
    end
  end

  // Stage 2 next state: take new partial sums when stage 1 moves down
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_psum_d  = s2_psum_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_psum_d = s2_sum;
      end
    end
  end

`ifdef TNS_DEC_OVF_EN
  logic [LANES-1:0] s3_ovf_q, s3_ovf_d;
`endif

  // Stage 3 next state: final per-lane sum, truncated, plus overflow detect
  always_comb begin
    logic [SUM_W-1:0] tot;
    tot        = '0;
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
`ifdef TNS_DEC_OVF_EN
    s3_ovf_d   = s3_ovf_q;
`endif
    if (s3_load) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        for (int l = 0; l < LANES; l++) begin
          tot = '0;
          for (int g = 0; g < NGRP; g++) begin
            tot = tot + s2_psum_q[l][g];
          end
          s3_data_d[l*DATA_W +: DATA_W] = tot[DATA_W-1:0];
`ifdef TNS_DEC_OVF_EN
          s3_ovf_d[l] = (tot >> DATA_W) != '0;
`endif
        end
      end
    end
  end

  // Completed-transfer counter, wraps naturally at 32 bits
  always_comb begin
    cnt_d = out_xfer ? cnt_q + 32'd1 : cnt_q;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Datapath registers whose contents only matter while their valid is set
  always_ff @(posedge clk) begin
    s1_code_q <= s1_code_d;
    s2_psum_q <= s2_psum_d;
  end

`ifdef TNS_DEC_OVF_EN
  // Overflow flags travel with the stage 3 data
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_ovf_q <= '0;
    end else begin
      s3_ovf_q <= s3_ovf_d;
    end
  end
  assign out_ovf = s3_ovf_q;
`else
  assign out_ovf = '0;
`endif

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_tns_dec_pipe.sv
// tb/tb_tns_dec_pipe.sv - self-checking bench for tns_dec_pipe
module tb_tns_dec_pipe;

  localparam int A_DW = 27;
  localparam logic [A_DW-1:0] TNS01_C = 27'd1;
  localparam logic [A_DW-1:0] TNS11_C = 27'd98950096;
  localparam int BW [6] = '{1, 2, 3, 5, 8, 13};
  localparam logic [5:0] SC [6] = '{6'b000001, 6'b000010, 6'b000100,
                                    6'b000101, 6'b001000, 6'b001001};
`ifdef TNS_DEC_OVF_EN
  localparam logic [1:0] C_OVF_EXP = 2'b11;
`else
  localparam logic [1:0] C_OVF_EXP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [30:0]     a_in_code;
  logic [A_DW-1:0] a_out_data;
  logic [0:0]      a_out_ovf;
  logic [31:0]     a_word_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [11:0] b_in_code;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ovf;
  logic [31:0] b_word_cnt;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [11:0] c_in_code;
  logic [9:0]  c_out_data;
  logic [1:0]  c_out_ovf;
  logic [31:0] c_word_cnt;

  tns_dec_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_code(a_in_code), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf), .word_cnt(a_word_cnt)
  );

  tns_dec_pipe #(
    .LANES(2), .CODE_W(6), .DATA_W(8),
    .WEIGHTS({8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1}), .GRP(4)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_code(b_in_code), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf), .word_cnt(b_word_cnt)
  );

  tns_dec_pipe #(
    .LANES(2), .CODE_W(6), .DATA_W(5),
    .WEIGHTS({5'd13, 5'd8, 5'd5, 5'd3, 5'd2, 5'd1}), .GRP(4)
  ) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_code(c_in_code), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_ovf(c_out_ovf), .word_cnt(c_word_cnt)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] dec6(input logic [5:0] c);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 6; i++) begin
      if (c[i]) s = s + 8'(BW[i]);
    end
    return s;
  endfunction

  // Scoreboard for instance b: push at input transfer, pop at output transfer
  logic [17:0] sb_q [$];
  int held      = 0;
  int b_cnt_exp = 0;

  always @(negedge clk) begin
    logic [17:0] exp_v;
    if (rst) begin
      held      = 0;
      b_cnt_exp = 0;
      sb_q.delete();
    end else begin
      total++;
      if (b_in_ready !== ((held < 3) || b_out_ready)) begin
        bad++;
        $display("FAIL b_in_ready: got %b want %b (held=%0d)", b_in_ready, ((held < 3) || b_out_ready), held);
      end
      total++;
      if (b_word_cnt !== 32'(b_cnt_exp)) begin
        bad++;
        $display("FAIL b_word_cnt: got %0d want %0d", b_word_cnt, b_cnt_exp);
      end
      if (b_out_valid && b_out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL b_unexpected_out: got %h want no output", {b_out_ovf, b_out_data});
        end else begin
          exp_v = sb_q.pop_front();
          if ({b_out_ovf, b_out_data} !== exp_v) begin
            bad++;
            $display("FAIL b_sb_data: got %h want %h", {b_out_ovf, b_out_data}, exp_v);
          end
        end
        b_cnt_exp++;
        held--;
      end
      if (b_in_valid && b_in_ready) begin
        sb_q.push_back({2'b00, dec6(b_in_code[11:6]), dec6(b_in_code[5:0])});
        held++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({a_out_valid, b_out_valid, c_out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL rst_out_valid: got %b want 000", {a_out_valid, b_out_valid, c_out_valid});
    end
    total++;
    if ({a_out_data, b_out_data, c_out_data} !== '0) begin
      bad++;
      $display("FAIL rst_out_data: got %h want 0", {a_out_data, b_out_data, c_out_data});
    end
    total++;
    if ({a_out_ovf, b_out_ovf, c_out_ovf} !== 5'b0) begin
      bad++;
      $display("FAIL rst_out_ovf: got %b want 0", {a_out_ovf, b_out_ovf, c_out_ovf});
    end
    total++;
    if ({a_word_cnt, b_word_cnt, c_word_cnt} !== '0) begin
      bad++;
      $display("FAIL rst_word_cnt: got %h want 0", {a_word_cnt, b_word_cnt, c_word_cnt});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      bad++;
      $display("FAIL rst_in_ready: got %b want 111", {a_in_ready, b_in_ready, c_in_ready});
    end
  endtask

  task automatic test_default_zero();
    int n;
    a_in_code  = '0;
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n = 1;
    while (a_out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL a_zero_latency: got %0d want 3", n);
    end
    total++;
    if (a_out_data !== '0) begin
      bad++;
      $display("FAIL a_zero_data: got %0d want 0", a_out_data);
    end
    tick();
    total++;
    if (a_word_cnt !== 32'd1) begin
      bad++;
      $display("FAIL a_zero_cnt: got %0d want 1", a_word_cnt);
    end
  endtask

  task automatic test_default_onehot();
    int n;
    a_in_code  = 31'd1;
    a_in_valid = 1'b1;
    tick();
    a_in_code = 31'h4000_0000;
    tick();
    a_in_valid = 1'b0;
    a_in_code  = '0;
    n = 2;
    while (a_out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n !== 3 || a_out_data !== TNS01_C) begin
      bad++;
      $display("FAIL a_onehot_first: got %0d (cycles %0d) want %0d (cycles 3)", a_out_data, n, TNS01_C);
    end
    total++;
    if (a_out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL a_onehot_ovf: got %b want 0", a_out_ovf);
    end
    tick();
    total++;
    if (a_out_valid !== 1'b1 || a_out_data !== TNS11_C) begin
      bad++;
      $display("FAIL a_onehot_second: got %0d valid %b want %0d valid 1", a_out_data, a_out_valid, TNS11_C);
    end
    tick();
    total++;
    if (a_word_cnt !== 32'd3) begin
      bad++;
      $display("FAIL a_onehot_cnt: got %0d want 3", a_word_cnt);
    end
  endtask

  task automatic test_overflow();
    int n;
    c_out_ready = 1'b1;
    c_in_code   = {6'b111111, 6'b111111};
    c_in_valid  = 1'b1;
    tick();
    c_in_valid = 1'b0;
    n = 1;
    while (c_out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n !== 3 || c_out_data !== 10'd0) begin
      bad++;
      $display("FAIL c_ovf_data: got %h (cycles %0d) want 0 (cycles 3)", c_out_data, n);
    end
    total++;
    if (c_out_ovf !== C_OVF_EXP) begin
      bad++;
      $display("FAIL c_ovf_flag: got %b want %b", c_out_ovf, C_OVF_EXP);
    end
    tick();
  endtask

  task automatic test_decode();
    int n;
    b_out_ready = 1'b1;
    b_in_code   = {6'b111111, 6'b101001};
    b_in_valid  = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n = 1;
    while (b_out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (b_out_data !== {8'd32, 8'd19} || b_out_ovf !== 2'b00) begin
      bad++;
      $display("FAIL b_decode_fixed: got %h ovf %b want 2013 ovf 00", b_out_data, b_out_ovf);
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      b_in_code  = 12'($urandom);
      b_in_valid = 1'b1;
      tick();
    end
    b_in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL b_decode_drain: got %0d pending want 0", sb_q.size());
    end
  endtask

  task automatic test_stall();
    int k;
    rst = 1'b1;
    b_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    k = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      b_out_ready = !(cyc >= 4 && cyc <= 9);
      if (k < 6) begin
        b_in_valid = 1'b1;
        b_in_code  = {SC[k], SC[k]};
      end else begin
        b_in_valid = 1'b0;
      end
      #1;
      if (cyc == 4) begin
        total++;
        if (b_in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready_fall: got %b want 0", b_in_ready);
        end
      end
      if (cyc >= 4 && cyc <= 9) begin
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== {8'd1, 8'd1}) begin
          bad++;
          $display("FAIL stall_hold cyc %0d: got %h valid %b want 0101 valid 1", cyc, b_out_data, b_out_valid);
        end
      end
      if (b_in_valid && b_in_ready) k++;
      tick();
    end
    b_in_valid = 1'b0;
    total++;
    if (k !== 6 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL stall_complete: got sent %0d pending %0d want sent 6 pending 0", k, sb_q.size());
    end
    total++;
    if (b_word_cnt !== 32'd6) begin
      bad++;
      $display("FAIL stall_word_cnt: got %0d want 6", b_word_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int n;
    b_out_ready = 1'b0;
    k = 0;
    n = 0;
    while (k < 3 && n < 20) begin
      b_in_valid = 1'b1;
      b_in_code  = {SC[k], SC[k]};
      #1;
      if (b_in_ready) k++;
      tick();
      n++;
    end
    b_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (b_out_valid !== 1'b0 || b_word_cnt !== 32'd0 || b_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_state: got valid %b cnt %0d ready %b want 0 0 1", b_out_valid, b_word_cnt, b_in_ready);
    end
    b_out_ready = 1'b1;
    b_in_code   = {6'b000001, 6'b000001};
    b_in_valid  = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n = 1;
    while (b_out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n !== 3 || b_out_data !== {8'd1, 8'd1}) begin
      bad++;
      $display("FAIL mid_reset_word: got %h (cycles %0d) want 0101 (cycles 3)", b_out_data, n);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 300; i++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_code   = 12'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (sb_q.size() != 0 || b_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got pending %0d valid %b want 0 0", sb_q.size(), b_out_valid);
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_code = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_code = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_code = '0; c_out_ready = 1'b1;
    test_reset();
    test_default_zero();
    test_default_onehot();
    test_overflow();
    test_decode();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
